mult_property_monitor: RTL

- Parametrised N-channel checker that sits beside a bank of sequential multipliers sharing one start strobe.
- Per run it timestamps each channel's productDone and captures each product.
- Reports a timing leak (done skew), value mismatches under a selectable equality mode, and timeout.
- Successor to the fixed four-multiplier tester: generic channel count, latency measurement, sticky results and a report handshake.

---
 rtl/mult_property_monitor.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mult_property_monitor.sv
// N-channel checker for a bank of sequential multipliers: per-run done latency, skew, value compare, timeout.
// Results appear in the single REPORT cycle (result_valid) and then hold until the next REPORT; no backpressure.
module mult_property_monitor #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int LAT_W    = 16,
  parameter int TIMEOUT  = 2*WIDTH+8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic [CHANNELS-1:0]          done_vec,
  input  logic [CHANNELS*2*WIDTH-1:0]  product_bus,
  output logic                         busy,
  output logic                         result_valid,
  output logic                         timing_leak,
  output logic [LAT_W-1:0]             skew,
  output logic                         value_mismatch,
  output logic [CHANNELS-1:0]          mismatch_mask,
  output logic                         timeout
);

  localparam int PW = 2*WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  state_t              state, stateNext;
  logic [LAT_W-1:0]    cycleCnt;
  logic [CHANNELS-1:0] captured, capNext;
  logic [LAT_W-1:0]    lat  [CHANNELS];
  logic [PW-1:0]       prod [CHANNELS];
  logic [1:0]          modeReg;
  logic                timedOut;

  logic                leakQ, toQ;
  logic [LAT_W-1:0]    skewQ;
  logic [CHANNELS-1:0] maskQ;

  logic                leakC;
  logic [LAT_W-1:0]    skewC, latMax, latMin;
  logic [CHANNELS-1:0] maskC;
  int                  nCap;

  always_comb begin
    stateNext = state;
    capNext   = captured | done_vec;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN: begin
        if (&capNext)                             stateNext = REPORT;
        else if (cycleCnt == LAT_W'(TIMEOUT))     stateNext = REPORT;
      end
      REPORT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cycleCnt <= '0;
      captured <= '0;
      modeReg  <= '0;
      timedOut <= 1'b0;
      leakQ    <= 1'b0;
      toQ      <= 1'b0;
      skewQ    <= '0;
      maskQ    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        lat[i]  <= '0;
        prod[i] <= '0;
      end
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (start) begin
            modeReg  <= mode;
            captured <= '0;
            cycleCnt <= LAT_W'(1);
            timedOut <= 1'b0;
          end
        end
        RUN: begin
          // First done wins; later pulses and product changes are ignored.
          for (int i = 0; i < CHANNELS; i++) begin
            if (done_vec[i] && !captured[i]) begin
              lat[i]  <= cycleCnt;
              prod[i] <= product_bus[i*PW +: PW];
            end
          end
          captured <= capNext;
          if (stateNext == RUN) cycleCnt <= cycleCnt + LAT_W'(1);
          if (stateNext == REPORT && !(&capNext)) timedOut <= 1'b1;
        end
        REPORT: begin
          leakQ <= leakC;
          toQ   <= timedOut;
          skewQ <= skewC;
          maskQ <= maskC;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    latMax = '0;
    latMin = '1;
    nCap   = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (captured[i]) begin
        nCap = nCap + 1;
        if (lat[i] > latMax) latMax = lat[i];
        if (lat[i] < latMin) latMin = lat[i];
      end
    end
    skewC = (nCap >= 2) ? (latMax - latMin) : '0;
    leakC = (skewC != '0) || (timedOut && (|captured));

    maskC = ~captured;
    case (modeReg)
      2'd0: begin
        if (!captured[0]) maskC = '1;
        else
          for (int i = 1; i < CHANNELS; i++)
            if (prod[i] != prod[0]) maskC[i] = 1'b1;
      end
      2'd1: begin
        for (int k = 0; k < CHANNELS/2; k++) begin
          if (!captured[2*k] || !captured[2*k+1] || (prod[2*k] != prod[2*k+1])) begin
            maskC[2*k]   = 1'b1;
            maskC[2*k+1] = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign busy           = (state == RUN);
  assign result_valid   = (state == REPORT);
  assign timing_leak    = result_valid ? leakC    : leakQ;
  assign skew           = result_valid ? skewC    : skewQ;
  assign mismatch_mask  = result_valid ? maskC    : maskQ;
  assign timeout        = result_valid ? timedOut : toQ;
  assign value_mismatch = |mismatch_mask;

endmodule
